v_upd_ingress: RTL and testbench

//  Ingress queue directly upstream of v_pipe_update on the List Update Bus.
//  - Absorbs update commands, which arrive with no backpressure.
//  - Holds them while table initialisation is busy.
//  - Issues them in order to the update pipe.
//  - Stalls a command whose context (prod_id) still has a read-modify-write
//    in flight in the pipe (RAW hazard on the state SRAM).
//

---
 rtl/v_upd_ingress.sv | 168 ++++++++++++++++
 tb/tb_v_upd_ingress.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_upd_ingress.sv
// Ingress queue in front of v_pipe_update. Buffers update commands that
// arrive without backpressure, holds them while table init is busy, and
// issues them in order, stalling a head whose prod_id is still inside the
// pipe's read-modify-write window.
//
// Handshake: the upstream side has no ready; a command presented with
// i_upd_vld=1 is either written to the tail in that cycle or dropped (and
// o_overflow_r latched). Downstream has no ready either; o_upd_vld is a
// one-cycle pulse and the o_upd_* payload is valid in that cycle.

package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [2:0]  cmd_t;
    typedef logic [31:0] key_t;
    typedef logic [15:0] size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;
endpackage

module v_upd_ingress #(
    parameter int DEPTH    = 8,
    parameter int HAZARD_N = 3,
    parameter int ID_W     = $bits(v_pkg::id_t),
    parameter int CMD_W    = $bits(v_pkg::cmd_t),
    parameter int KEY_W    = $bits(v_pkg::key_t),
    parameter int SIZE_W   = $bits(v_pkg::size_t),
    parameter int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_upd_vld,
    input  logic [ID_W-1:0]   i_upd_prod_id,
    input  logic [CMD_W-1:0]  i_upd_cmd,
    input  logic [KEY_W-1:0]  i_upd_key,
    input  logic [SIZE_W-1:0] i_upd_size,
    input  logic              i_busy,
    output logic              o_upd_vld,
    output logic [ID_W-1:0]   o_upd_prod_id,
    output logic [CMD_W-1:0]  o_upd_cmd,
    output logic [KEY_W-1:0]  o_upd_key,
    output logic [SIZE_W-1:0] o_upd_size,
    output logic [LVL_W-1:0]  o_level_r,
    output logic              o_full_r,
    output logic              o_overflow_r
);

    localparam int AW = $clog2(DEPTH);

    v_pkg::upd_t       mem [DEPTH];
    v_pkg::upd_t       head;
    v_pkg::upd_t       in_entry;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              empty;
    logic              hazard;
    logic              issue;
    logic              enq;
    logic              drop;

    // Recently issued ids, slot 0 newest; an id stays here HAZARD_N cycles.
    logic [HAZARD_N-1:0] hist_vld;
    logic [ID_W-1:0]     hist_id [HAZARD_N];

    assign head     = mem[rd_ptr];
    assign in_entry = '{prod_id: i_upd_prod_id, cmd: i_upd_cmd,
                        key: i_upd_key, size: i_upd_size};
    assign empty    = (o_level_r == '0);

    // RAW hazard: head id matches any id still in the pipe's RMW window.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_N; i++) begin
            if (hist_vld[i] && (hist_id[i] == head.prod_id)) begin
                hazard = 1'b1;
            end
        end
    end

    // Issue/enqueue decisions; a full queue still accepts when it pops this cycle.
    always_comb begin
        issue = !empty && !i_busy && !hazard;
        enq   = i_upd_vld && (!o_full_r || issue);
        drop  = i_upd_vld && !enq;
    end

    // Next occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        level_nxt = o_level_r;
        case ({enq, issue})
            2'b10:   level_nxt = o_level_r + LVL_W'(1);
            2'b01:   level_nxt = o_level_r - LVL_W'(1);
            default: level_nxt = o_level_r;
        endcase
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers, occupancy, full and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_level_r    <= '0;
            o_full_r     <= 1'b0;
            o_overflow_r <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_level_r <= level_nxt;
            o_full_r  <= (level_nxt == LVL_W'(DEPTH));
            if (drop) begin
                o_overflow_r <= 1'b1;
            end
        end
    end

    // Hazard history shifts every cycle, including while busy, so old ids age out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_vld <= '0;
            for (int i = 0; i < HAZARD_N; i++) begin
                hist_id[i] <= '0;
            end
        end else begin
            for (int i = HAZARD_N - 1; i > 0; i--) begin
                hist_vld[i] <= hist_vld[i-1];
                hist_id[i]  <= hist_id[i-1];
            end
            hist_vld[0] <= issue;
            hist_id[0]  <= head.prod_id;
        end
    end

    // Registered issue port: one-cycle valid pulse, payload held between issues.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_upd_vld     <= 1'b0;
            o_upd_prod_id <= '0;
            o_upd_cmd     <= '0;
            o_upd_key     <= '0;
            o_upd_size    <= '0;
        end else begin
            o_upd_vld <= issue;
            if (issue) begin
                o_upd_prod_id <= head.prod_id;
                o_upd_cmd     <= head.cmd;
                o_upd_key     <= head.key;
                o_upd_size    <= head.size;
            end
        end
    end

endmodule

// File: tb/tb_v_upd_ingress.sv
// Directed bench for v_upd_ingress: ordering, latency, hazard stall,
// busy hold, overflow, full push+pop, pointer wrap and mid-run reset.

module tb_v_upd_ingress;

    logic        clk;
    logic        rst;
    logic        i_upd_vld;
    logic [7:0]  i_upd_prod_id;
    logic [2:0]  i_upd_cmd;
    logic [31:0] i_upd_key;
    logic [15:0] i_upd_size;
    logic        i_busy;
    logic        o_upd_vld;
    logic [7:0]  o_upd_prod_id;
    logic [2:0]  o_upd_cmd;
    logic [31:0] o_upd_key;
    logic [15:0] o_upd_size;
    logic [3:0]  o_level_r;
    logic        o_full_r;
    logic        o_overflow_r;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_id[$];
    logic [2:0]  obs_cmd[$];
    logic [31:0] obs_key[$];
    logic [15:0] obs_size[$];
    int          obs_cyc[$];

    v_upd_ingress dut (
        .clk           (clk),
        .rst           (rst),
        .i_upd_vld     (i_upd_vld),
        .i_upd_prod_id (i_upd_prod_id),
        .i_upd_cmd     (i_upd_cmd),
        .i_upd_key     (i_upd_key),
        .i_upd_size    (i_upd_size),
        .i_busy        (i_busy),
        .o_upd_vld     (o_upd_vld),
        .o_upd_prod_id (o_upd_prod_id),
        .o_upd_cmd     (o_upd_cmd),
        .o_upd_key     (o_upd_key),
        .o_upd_size    (o_upd_size),
        .o_level_r     (o_level_r),
        .o_full_r      (o_full_r),
        .o_overflow_r  (o_overflow_r)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Records every issued command with the cycle it appeared in.
    always @(negedge clk) begin
        if (o_upd_vld) begin
            obs_id.push_back(o_upd_prod_id);
            obs_cmd.push_back(o_upd_cmd);
            obs_key.push_back(o_upd_key);
            obs_size.push_back(o_upd_size);
            obs_cyc.push_back(cyc);
        end
    end

    // ---------------- payload derived from id ----------------
    function automatic logic [2:0] mk_cmd(input logic [7:0] id);
        mk_cmd = id[2:0] ^ 3'b101;
    endfunction

    function automatic logic [31:0] mk_key(input logic [7:0] id);
        mk_key = {id, ~id, id ^ 8'h5a, 8'h33};
    endfunction

    function automatic logic [15:0] mk_size(input logic [7:0] id);
        mk_size = {id, 8'h01};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_push(input logic [7:0] id);
        i_upd_vld     = 1'b1;
        i_upd_prod_id = id;
        i_upd_cmd     = mk_cmd(id);
        i_upd_key     = mk_key(id);
        i_upd_size    = mk_size(id);
    endtask

    task automatic push1(input logic [7:0] id);
        set_push(id);
        tick();
        i_upd_vld = 1'b0;
    endtask

    task automatic clear_obs;
        obs_id.delete();
        obs_cmd.delete();
        obs_key.delete();
        obs_size.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset;
        rst = 1'b0;
        i_upd_vld = 1'b0;
        i_busy = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        i_upd_prod_id = 8'(($urandom_range(0, 255)));
        do_reset();
        n_checks++;
        if (o_upd_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld got %0d exp 0", o_upd_vld);
        end
        n_checks++;
        if (o_level_r !== 4'd0) begin
            n_fail++; $display("FAIL reset_level got %0d exp 0", o_level_r);
        end
        n_checks++;
        if (o_full_r !== 1'b0) begin
            n_fail++; $display("FAIL reset_full got %0d exp 0", o_full_r);
        end
        n_checks++;
        if (o_overflow_r !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %0d exp 0", o_overflow_r);
        end
        n_checks++;
        if (o_upd_prod_id !== 8'd0) begin
            n_fail++; $display("FAIL reset_id got %0d exp 0", o_upd_prod_id);
        end
    endtask

    task automatic test_order;
        int t0;
        clear_obs();
        exp_q = '{8'd1, 8'd2, 8'd3};
        t0 = cyc;
        set_push(8'd1); tick();
        set_push(8'd2); tick();
        set_push(8'd3); tick();
        i_upd_vld = 1'b0;
        idle(6);
        n_checks++;
        if (obs_id.size() !== 3) begin
            n_fail++; $display("FAIL order_count got %0d exp 3", obs_id.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_id[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL order_id[%0d] got %0d exp %0d", i, obs_id[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc[i] !== t0 + 2 + i) begin
                    n_fail++; $display("FAIL order_latency[%0d] got %0d exp %0d", i, obs_cyc[i], t0 + 2 + i);
                end
                n_checks++;
                if (obs_cmd[i] !== mk_cmd(exp_q[i])) begin
                    n_fail++; $display("FAIL order_cmd[%0d] got %0h exp %0h", i, obs_cmd[i], mk_cmd(exp_q[i]));
                end
                n_checks++;
                if (obs_key[i] !== mk_key(exp_q[i])) begin
                    n_fail++; $display("FAIL order_key[%0d] got %0h exp %0h", i, obs_key[i], mk_key(exp_q[i]));
                end
                n_checks++;
                if (obs_size[i] !== mk_size(exp_q[i])) begin
                    n_fail++; $display("FAIL order_size[%0d] got %0h exp %0h", i, obs_size[i], mk_size(exp_q[i]));
                end
            end
        end
        n_checks++;
        if (o_level_r !== 4'd0) begin
            n_fail++; $display("FAIL order_level got %0d exp 0", o_level_r);
        end
    endtask

    task automatic test_hazard;
        int t0;
        int exp_c[2];
        // same id back-to-back: second waits out the RMW window
        clear_obs();
        exp_q = '{8'd5, 8'd5};
        t0 = cyc;
        set_push(8'd5); tick();
        set_push(8'd5); tick();
        i_upd_vld = 1'b0;
        idle(8);
        exp_c = '{t0 + 2, t0 + 6};
        n_checks++;
        if (obs_id.size() !== 2) begin
            n_fail++; $display("FAIL hazard_same_count got %0d exp 2", obs_id.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_id[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL hazard_same_id[%0d] got %0d exp %0d", i, obs_id[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc[i] !== exp_c[i]) begin
                    n_fail++; $display("FAIL hazard_same_cycle[%0d] got %0d exp %0d", i, obs_cyc[i], exp_c[i]);
                end
            end
        end
        // distinct ids: no stall
        clear_obs();
        exp_q = '{8'd5, 8'd6};
        t0 = cyc;
        set_push(8'd5); tick();
        set_push(8'd6); tick();
        i_upd_vld = 1'b0;
        idle(6);
        exp_c = '{t0 + 2, t0 + 3};
        n_checks++;
        if (obs_id.size() !== 2) begin
            n_fail++; $display("FAIL hazard_diff_count got %0d exp 2", obs_id.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_id[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL hazard_diff_id[%0d] got %0d exp %0d", i, obs_id[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc[i] !== exp_c[i]) begin
                    n_fail++; $display("FAIL hazard_diff_cycle[%0d] got %0d exp %0d", i, obs_cyc[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_busy_overflow;
        int tb;
        clear_obs();
        i_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push1(8'(10 + k));
            exp_q.push_back(8'(10 + k));
        end
        tick();
        n_checks++;
        if (obs_id.size() !== 0) begin
            n_fail++; $display("FAIL busy_no_issue got %0d exp 0", obs_id.size());
        end
        n_checks++;
        if (o_full_r !== 1'b1) begin
            n_fail++; $display("FAIL busy_full got %0d exp 1", o_full_r);
        end
        n_checks++;
        if (o_level_r !== 4'd8) begin
            n_fail++; $display("FAIL busy_level got %0d exp 8", o_level_r);
        end
        n_checks++;
        if (o_overflow_r !== 1'b0) begin
            n_fail++; $display("FAIL busy_no_overflow got %0d exp 0", o_overflow_r);
        end
        push1(8'd18);
        n_checks++;
        if (o_overflow_r !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set got %0d exp 1", o_overflow_r);
        end
        n_checks++;
        if (o_level_r !== 4'd8) begin
            n_fail++; $display("FAIL overflow_level got %0d exp 8", o_level_r);
        end
        tb = cyc;
        i_busy = 1'b0;
        idle(12);
        n_checks++;
        if (obs_id.size() !== 8) begin
            n_fail++; $display("FAIL drain_count got %0d exp 8", obs_id.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (obs_id[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL drain_id[%0d] got %0d exp %0d", i, obs_id[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc[i] !== tb + 1 + i) begin
                    n_fail++; $display("FAIL drain_cycle[%0d] got %0d exp %0d", i, obs_cyc[i], tb + 1 + i);
                end
            end
        end
        n_checks++;
        if (o_overflow_r !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky got %0d exp 1", o_overflow_r);
        end
        n_checks++;
        if (o_level_r !== 4'd0 || o_full_r !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty got level %0d full %0d exp 0 0", o_level_r, o_full_r);
        end
    endtask

    task automatic test_full_wrap;
        int tb;
        do_reset();
        clear_obs();
        i_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push1(8'(20 + k));
            exp_q.push_back(8'(20 + k));
        end
        // release busy and push into the full queue in the same cycle
        tb = cyc;
        i_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_push(8'(28 + k));
            exp_q.push_back(8'(28 + k));
            tick();
            n_checks++;
            if (o_level_r !== 4'd8) begin
                n_fail++; $display("FAIL full_push_level[%0d] got %0d exp 8", k, o_level_r);
            end
            n_checks++;
            if (o_overflow_r !== 1'b0) begin
                n_fail++; $display("FAIL full_push_overflow[%0d] got %0d exp 0", k, o_overflow_r);
            end
        end
        i_upd_vld = 1'b0;
        idle(12);
        n_checks++;
        if (obs_id.size() !== 28) begin
            n_fail++; $display("FAIL wrap_count got %0d exp 28", obs_id.size());
        end else begin
            for (int i = 0; i < 28; i++) begin
                n_checks++;
                if (obs_id[i] !== exp_q[i] || obs_cyc[i] !== tb + 1 + i) begin
                    n_fail++;
                    $display("FAIL wrap[%0d] got id %0d cyc %0d exp id %0d cyc %0d",
                             i, obs_id[i], obs_cyc[i], exp_q[i], tb + 1 + i);
                end
            end
        end
        n_checks++;
        if (o_level_r !== 4'd0) begin
            n_fail++; $display("FAIL wrap_level got %0d exp 0", o_level_r);
        end
    endtask

    task automatic test_reset_mid;
        int t0;
        i_busy = 1'b1;
        for (int k = 0; k < 8; k++) push1(8'(50 + k));
        push1(8'd58);
        n_checks++;
        if (o_overflow_r !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_overflow got %0d exp 1", o_overflow_r);
        end
        // issue 50..53, leaving four queued and 51..53 in the hazard window
        i_busy = 1'b0;
        idle(4);
        i_busy = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_obs();
        n_checks++;
        if (o_level_r !== 4'd0) begin
            n_fail++; $display("FAIL mid_level got %0d exp 0", o_level_r);
        end
        n_checks++;
        if (o_upd_vld !== 1'b0) begin
            n_fail++; $display("FAIL mid_vld got %0d exp 0", o_upd_vld);
        end
        n_checks++;
        if (o_overflow_r !== 1'b0 || o_full_r !== 1'b0) begin
            n_fail++; $display("FAIL mid_flags got ovf %0d full %0d exp 0 0", o_overflow_r, o_full_r);
        end
        // 53 was issued just before reset; it must not be treated as a hazard
        i_busy = 1'b0;
        t0 = cyc;
        push1(8'd53);
        idle(8);
        n_checks++;
        if (obs_id.size() !== 1) begin
            n_fail++; $display("FAIL mid_discard_count got %0d exp 1", obs_id.size());
        end else begin
            n_checks++;
            if (obs_id[0] !== 8'd53) begin
                n_fail++; $display("FAIL mid_post_id got %0d exp 53", obs_id[0]);
            end
            n_checks++;
            if (obs_cyc[0] !== t0 + 2) begin
                n_fail++; $display("FAIL mid_post_latency got %0d exp %0d", obs_cyc[0], t0 + 2);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        i_upd_vld = 1'b0;
        i_upd_prod_id = '0;
        i_upd_cmd = '0;
        i_upd_key = '0;
        i_upd_size = '0;
        i_busy = 1'b0;
        idle(2);
        test_reset();
        test_order();
        test_hazard();
        test_busy_overflow();
        test_full_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
